// File: rtl/uart_key_pacer.sv
`default_nettype none
// ============================================================================
// Module   : uart_key_pacer
// Purpose  : Type-ahead FIFO that replays UART bytes as timed keystrokes
//            (held HOLD_CYCLES, released GAP_CYCLES) for the PET key matrix.
//            Optional macro CRLF_FOLD_EN drops an 8'h0A that follows an 8'h0D.
// Revision : 1.0 - initial release
// ============================================================================
module uart_key_pacer #(
    parameter int DEPTH_LOG2  = 4,
    parameter int HOLD_CYCLES = 2000000,
    parameter int GAP_CYCLES  = 1000000,
    parameter int CNT_W       = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            in_data,
    input  logic                  in_strobe,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  ovf_clr,
    output logic [7:0]            key_code,
    output logic                  key_valid,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  busy
);

    localparam int                 DEPTH       = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH     = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] c_PTR_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [CNT_W-1:0]   c_HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_TMR_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    logic [7:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    logic                r_overflow;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_timer;
    logic [CNT_W-1:0]    w_timer_nxt;
    logic [7:0]          r_key_code;
    logic [7:0]          w_key_code_nxt;
    logic                r_key_valid;
    logic                w_key_valid_nxt;

    logic [DEPTH_LOG2:0] w_count;
    logic                w_full;
    logic                w_empty;
    logic                w_fold;
    logic                w_push_req;
    logic                w_push;
    logic                w_drop;
    logic                w_slot_free;
    logic                w_pop;

    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == c_DEPTH);
    assign w_empty = (w_count == '0);

`ifdef CRLF_FOLD_EN
    logic r_last_cr;

    assign w_fold = r_last_cr && (in_data == 8'h0A);

    // Any strobe that is not a queued CR ends a CR/LF pair, including the folded LF itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_cr <= 1'b0;
        end else if (flush) begin
            r_last_cr <= 1'b0;
        end else if (in_strobe) begin
            r_last_cr <= w_push && (in_data == 8'h0D);
        end
    end
`else
    assign w_fold = 1'b0;
`endif

    assign w_push_req = in_strobe && !flush && !w_fold;
    assign w_push     = w_push_req && !w_full;
    assign w_drop     = w_push_req && w_full;

    // Last GAP cycle counts as idle so back-to-back keys see exactly GAP_CYCLES low.
    assign w_slot_free = (r_state == ST_IDLE) || ((r_state == ST_GAP) && (r_timer == '0));
    assign w_pop       = w_slot_free && enable && !w_empty && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_key_code  <= 8'h00;
            r_key_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_key_code  <= w_key_code_nxt;
            r_key_valid <= w_key_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_key_code_nxt  = r_key_code;
        w_key_valid_nxt = r_key_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_key_code_nxt  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
                    w_key_valid_nxt = 1'b1;
                    w_timer_nxt     = c_HOLD_LOAD;
                    w_state_nxt     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_timer == '0) begin
                    w_key_valid_nxt = 1'b0;
                    w_timer_nxt     = c_GAP_LOAD;
                    w_state_nxt     = ST_GAP;
                end else begin
                    w_timer_nxt = r_timer - c_TMR_ONE;
                end
            end
            ST_GAP: begin
                if (r_timer != '0) begin
                    w_timer_nxt = r_timer - c_TMR_ONE;
                end else if (w_pop) begin
                    w_key_code_nxt  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
                    w_key_valid_nxt = 1'b1;
                    w_timer_nxt     = c_HOLD_LOAD;
                    w_state_nxt     = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_key_valid_nxt = 1'b0;
            end
        endcase
    end

    assign key_code   = r_key_code;
    assign key_valid  = r_key_valid;
    assign fifo_count = w_count;
    assign overflow   = r_overflow;
    assign busy       = (r_state != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_key_pacer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_key_pacer
// Purpose  : Self-checking bench for uart_key_pacer against a queue/timeline
//            reference model; honours CRLF_FOLD_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_key_pacer;

    localparam int DL2   = 2;
    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int GAP   = 2;

    logic           clk       = 1'b0;
    logic           reset     = 1'b0;
    logic [7:0]     in_data   = 8'h00;
    logic           in_strobe = 1'b0;
    logic           enable    = 1'b1;
    logic           flush     = 1'b0;
    logic           ovf_clr   = 1'b0;
    logic [7:0]     key_code;
    logic           key_valid;
    logic [DL2:0]   fifo_count;
    logic           overflow;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_key_pacer #(
        .DEPTH_LOG2  (DL2),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_strobe  (in_strobe),
        .enable     (enable),
        .flush      (flush),
        .ovf_clr    (ovf_clr),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy)
    );

    // Reference: a byte queue plus the start cycle of the latest key; pulse and
    // busy windows follow from arithmetic on that start cycle.
    logic [7:0]  mq[$];
    int          cyc     = 0;
    bit          started = 1'b0;
    int          s       = 0;
    int          free_at = 0;
    logic [7:0]  m_code  = 8'h00;
    bit          m_ovf   = 1'b0;
    bit          m_last_cr = 1'b0;
    logic [13:0] exp_obs = '0;
    logic [13:0] dut_obs;

    assign dut_obs = {key_valid, key_code, fifo_count, overflow, busy};

    always @(posedge clk or posedge reset) begin
        int sz;
        bit fold;
        bit drop;
        bit live;
        if (reset) begin
            mq.delete();
            started   = 1'b0;
            free_at   = 0;
            m_code    = 8'h00;
            m_ovf     = 1'b0;
            m_last_cr = 1'b0;
        end else begin
            sz   = mq.size();
            fold = 1'b0;
            drop = 1'b0;
            if (!flush && enable && sz > 0 && (!started || cyc >= free_at)) begin
                m_code  = mq.pop_front();
                started = 1'b1;
                s       = cyc + 1;
                free_at = cyc + HOLD + GAP;
            end
            if (flush) begin
                mq.delete();
                m_last_cr = 1'b0;
            end else if (in_strobe) begin
`ifdef CRLF_FOLD_EN
                fold = m_last_cr && (in_data == 8'h0A);
`endif
                if (!fold) begin
                    if (sz >= DEPTH) drop = 1'b1;
                    else mq.push_back(in_data);
                end
                m_last_cr = !fold && !drop && (in_data == 8'h0D);
            end
            if (ovf_clr) m_ovf = 1'b0;
            if (drop)    m_ovf = 1'b1;
            cyc++;
        end
        live    = started && (cyc < s + HOLD + GAP);
        exp_obs = {started && (cyc >= s) && (cyc < s + HOLD), m_code,
                   (DL2 + 1)'(mq.size()), m_ovf, live || (mq.size() != 0)};
    end

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", key_valid); end
        checks++;
        if (key_code !== 8'h00) begin failures++; $display("FAIL reset_code got=%h want=00", key_code); end
        checks++;
        if (fifo_count !== '0) begin failures++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", overflow); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
    endtask

    task automatic test_single();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dut_obs !== exp_obs) begin
                failures++;
                $display("FAIL single_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
            end
            checks++;
            if (key_valid !== (c >= 2 && c <= 5) || busy !== (c >= 1 && c <= 7) ||
                (c >= 2 && c <= 7 && key_code !== 8'h41)) begin
                failures++;
                $display("FAIL single_timing c=%0d valid=%b busy=%b code=%h want valid=%b busy=%b code=41",
                         c, key_valid, busy, key_code, (c >= 2 && c <= 5), (c >= 1 && c <= 7));
            end
            checks++;
            in_strobe = (c == 0);
            in_data   = 8'h41;
        end
        in_strobe = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] pat[3] = '{8'h31, 8'h32, 8'h33};
        logic [7:0] got[$];
        bit prev = 1'b0;
        int hi_len = 0, lo_len = 0, peak = 0;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (dut_obs !== exp_obs) begin
                failures++;
                $display("FAIL burst_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
            end
            checks++;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            if (key_valid) begin
                if (!prev) begin
                    if (got.size() > 0) begin
                        if (lo_len !== GAP) begin failures++; $display("FAIL burst_gap got=%0d want=%0d", lo_len, GAP); end
                        checks++;
                    end
                    got.push_back(key_code);
                    hi_len = 0;
                end
                hi_len++;
            end else begin
                if (prev) begin
                    if (hi_len !== HOLD) begin failures++; $display("FAIL burst_hold got=%0d want=%0d", hi_len, HOLD); end
                    checks++;
                    lo_len = 0;
                end
                lo_len++;
            end
            prev      = key_valid;
            in_strobe = (c < 3);
            in_data   = (c < 3) ? pat[c] : 8'h00;
        end
        in_strobe = 1'b0;
        if (got.size() !== 3 || got[0] !== 8'h31 || got[1] !== 8'h32 || got[2] !== 8'h33) begin
            failures++;
            $display("FAIL burst_codes got_n=%0d got=%p want=31,32,33", got.size(), got);
        end
        checks++;
        if (peak !== 2) begin failures++; $display("FAIL burst_peak got=%0d want=2", peak); end
        checks++;
    endtask

    task automatic test_overflow();
        logic [7:0] pat[5];
        logic [7:0] got[$];
        bit prev = 1'b0;
        foreach (pat[i]) pat[i] = 8'($urandom_range(8'h20, 8'h7E));
        enable = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (dut_obs !== exp_obs) begin
                failures++;
                $display("FAIL ovf_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
            end
            checks++;
            if (c == 5) begin
                if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
                    failures++;
                    $display("FAIL ovf_full count=%0d ovf=%b want count=4 ovf=1", fifo_count, overflow);
                end
                checks++;
                enable = 1'b1;
            end
            if (c == 37) begin
                if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b want=0", overflow); end
                checks++;
            end
            if (key_valid && !prev) got.push_back(key_code);
            prev      = key_valid;
            in_strobe = (c < 5);
            in_data   = (c < 5) ? pat[c] : 8'h00;
            ovf_clr   = (c == 36);
        end
        in_strobe = 1'b0;
        ovf_clr   = 1'b0;
        if (got.size() !== 4 || got[0] !== pat[0] || got[1] !== pat[1] ||
            got[2] !== pat[2] || got[3] !== pat[3]) begin
            failures++;
            $display("FAIL ovf_order got=%p want=%h,%h,%h,%h", got, pat[0], pat[1], pat[2], pat[3]);
        end
        checks++;
    endtask

    task automatic test_flush();
        int rises = 0, hi_len = 0;
        bit prev = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (dut_obs !== exp_obs) begin
                failures++;
                $display("FAIL flush_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
            end
            checks++;
            if (c == 3 && (fifo_count !== 3'd2 || key_valid !== 1'b1 || key_code !== 8'h41)) begin
                failures++;
                $display("FAIL flush_setup count=%0d valid=%b code=%h want 2,1,41", fifo_count, key_valid, key_code);
            end
            if (c == 4 && fifo_count !== '0) begin
                failures++;
                $display("FAIL flush_count got=%0d want=0", fifo_count);
            end
            if (c == 3 || c == 4) checks++;
            if (key_valid && !prev) begin rises++; hi_len = 0; end
            if (key_valid) hi_len++;
            prev      = key_valid;
            in_strobe = (c < 3);
            in_data   = 8'h41 + 8'(c);
            flush     = (c == 3);
        end
        in_strobe = 1'b0;
        flush     = 1'b0;
        if (rises !== 1 || hi_len !== HOLD) begin
            failures++;
            $display("FAIL flush_keys rises=%0d hold=%0d want rises=1 hold=%0d", rises, hi_len, HOLD);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] got[$];
        bit prev = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (dut_obs !== exp_obs) begin
                failures++;
                $display("FAIL rstmid_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
            end
            checks++;
            in_strobe = (c < 3);
            in_data   = 8'h55 + 8'(c);
        end
        in_strobe = 1'b0;
        reset     = 1'b1;
        #1;
        if (key_valid !== 1'b0 || fifo_count !== '0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async valid=%b count=%0d busy=%b want 0,0,0", key_valid, fifo_count, busy);
        end
        checks++;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (dut_obs !== exp_obs) begin
                failures++;
                $display("FAIL rstmid_after c=%0d got=%h want=%h", c, dut_obs, exp_obs);
            end
            checks++;
            if (key_valid && !prev) got.push_back(key_code);
            prev      = key_valid;
            in_strobe = (c == 0);
            in_data   = 8'h66;
        end
        in_strobe = 1'b0;
        if (got.size() !== 1 || got[0] !== 8'h66) begin
            failures++;
            $display("FAIL rstmid_key got=%p want=66", got);
        end
        checks++;
    endtask

    task automatic test_crlf();
        logic [7:0] pat[3] = '{8'h0D, 8'h0A, 8'h0A};
        logic [7:0] got[$];
        logic [7:0] want[$];
        bit prev = 1'b0;
`ifdef CRLF_FOLD_EN
        want = '{8'h0D, 8'h0A};
`else
        want = '{8'h0D, 8'h0A, 8'h0A};
`endif
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            if (dut_obs !== exp_obs) begin
                failures++;
                $display("FAIL crlf_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
            end
            checks++;
            if (key_valid && !prev) got.push_back(key_code);
            prev      = key_valid;
            in_strobe = (c < 3);
            in_data   = (c < 3) ? pat[c] : 8'h00;
        end
        in_strobe = 1'b0;
        if (got !== want) begin
            failures++;
            $display("FAIL crlf_keys got=%p want=%p", got, want);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 940; c++) begin
            @(negedge clk);
            if (dut_obs !== exp_obs) begin
                failures++;
                $display("FAIL random_model c=%0d got=%h want=%h", c, dut_obs, exp_obs);
            end
            checks++;
            if (c < 900) begin
                in_strobe = ($urandom_range(0, 99) < 40);
                case ($urandom_range(0, 3))
                    0:       in_data = 8'h0D;
                    1:       in_data = 8'h0A;
                    default: in_data = 8'($urandom);
                endcase
                enable  = ($urandom_range(0, 99) < 85);
                flush   = ($urandom_range(0, 99) < 2);
                ovf_clr = ($urandom_range(0, 99) < 5);
            end else begin
                in_strobe = 1'b0;
                enable    = 1'b1;
                flush     = 1'b0;
                ovf_clr   = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_crlf();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
